// File: rtl/fetch_unit_if.sv
// Bundle of run/stall/redirect controls, the instruction-memory port and the IR-stage outputs.
// The master modport is the fetch unit's view; the slave modport is its environment.
interface fetch_unit_if;
  logic        Run;
  logic        Stall;
  logic        Redirect;
  logic [15:0] Target;
  logic        MemAck;
  logic [15:0] MemData;
  logic        MemReq;
  logic [15:0] MemAddr;
  logic [15:0] IRInput;
  logic        IRWrite;
  logic [15:0] fromPC;
  logic [15:0] PCcur;
  logic        Busy;

  modport master (
    input  Run, Stall, Redirect, Target, MemAck, MemData,
    output MemReq, MemAddr, IRInput, IRWrite, fromPC, PCcur, Busy
  );

  modport slave (
    output Run, Stall, Redirect, Target, MemAck, MemData,
    input  MemReq, MemAddr, IRInput, IRWrite, fromPC, PCcur, Busy
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/DELIVER sequencer that reads one word per request,
// hands it to the IR stage and tracks PC, redirects and squashed in-flight requests.
module fetch_unit (
  input  logic          CLK,
  input  logic          RESET_N,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DELIVER = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] reqAddr_q, reqAddr_d;
  logic [15:0] pcCur_q, pcCur_d;
  logic [15:0] ir_q, ir_d;
  logic        squash_q, squash_d;
  logic        memReq;
  logic        irWrite;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      pc_q      <= 16'h0000;
      reqAddr_q <= 16'h0000;
      pcCur_q   <= 16'h0000;
      ir_q      <= 16'h0000;
      squash_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      reqAddr_q <= reqAddr_d;
      pcCur_q   <= pcCur_d;
      ir_q      <= ir_d;
      squash_q  <= squash_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pcCur_d  = pcCur_q;
    ir_d     = ir_q;
    squash_d = squash_q;
    memReq   = 1'b0;
    irWrite  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.Redirect) pc_d = bus.Target;
        if (bus.Run)      state_d = FETCH;
      end

      FETCH: begin
        memReq = 1'b1;
        if (bus.MemAck) begin
          squash_d = 1'b0;
          if (!squash_q && !bus.Redirect) begin
            ir_d    = bus.MemData;
            pcCur_d = pc_q;
            state_d = DELIVER;
          end
        end
        // A redirect with no ack this cycle leaves a stale request in flight to be discarded.
        if (bus.Redirect) begin
          pc_d = bus.Target;
          if (!bus.MemAck) squash_d = 1'b1;
        end
      end

      DELIVER: begin
        if (!bus.Stall) begin
          irWrite = 1'b1;
          pc_d    = bus.Redirect ? bus.Target : pc_q + 16'h0001;
          state_d = bus.Run ? FETCH : IDLE;
        end else if (bus.Redirect) begin
          pc_d    = bus.Target;
          state_d = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // The request address is captured at request start so MemAddr never moves under an open request.
  always_comb begin
    reqAddr_d = reqAddr_q;
    if (state_d == FETCH && (state_q != FETCH || bus.MemAck)) reqAddr_d = pc_d;
  end

  assign bus.MemReq  = memReq;
  assign bus.MemAddr = reqAddr_q;
  assign bus.IRWrite = irWrite;
  assign bus.IRInput = ir_q;
  assign bus.PCcur   = pcCur_q;
  assign bus.fromPC  = pcCur_q + 16'h0001;
  assign bus.Busy    = (state_q != IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a per-cycle vector table for the streaming and stall
// behaviour, hand sequences for redirect/wrap/reset corners, and a delivery scoreboard.
module tb_fetch_unit;

  logic CLK;
  logic RESET_N;

  fetch_unit_if bus ();

  fetch_unit dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] data;
    logic [15:0] pc;
    logic [15:0] from;
  } exp_t;

  typedef struct {
    bit          run;
    bit          stall;
    bit          memAck;
    logic [15:0] memData;
    bit          accept;
    logic [15:0] expAddr;
    bit          expReq;
    bit          expIRWrite;
    bit          expBusy;
    bit          chkIR;
    logic [15:0] expIR;
  } vec_t;

  exp_t expQ[$];
  vec_t vecs[18];
  int   nCompared   = 0;
  int   nMismatched = 0;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Every IR load is matched against the oldest word the bench expects to be delivered.
  always @(negedge CLK) begin
    if (RESET_N && bus.IRWrite === 1'b1) begin
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL unexpectedIRWrite: got IRInput %h at PCcur %h, expected no IRWrite", bus.IRInput, bus.PCcur);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("sbIRInput", bus.IRInput, e.data);
        checkOutput("sbPCcur",   bus.PCcur,   e.pc);
        checkOutput("sbFromPC",  bus.fromPC,  e.from);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic driveInputs(input bit run, input bit stall, input bit redir, input logic [15:0] tgt,
                             input bit ack, input logic [15:0] data);
    bus.Run      = run;
    bus.Stall    = stall;
    bus.Redirect = redir;
    bus.Target   = tgt;
    bus.MemAck   = ack;
    bus.MemData  = data;
  endtask

  task automatic pushExp(input logic [15:0] data, input logic [15:0] pc);
    exp_t e;
    e.data = data;
    e.pc   = pc;
    e.from = pc + 16'h0001;
    expQ.push_back(e);
  endtask

  function automatic vec_t mk(bit run, bit stall, bit ack, logic [15:0] data, bit accept,
                              logic [15:0] addr, bit req, bit irw, bit busy, bit chkIR, logic [15:0] ir);
    vec_t v;
    v.run = run;  v.stall = stall;  v.memAck = ack;  v.memData = data;  v.accept = accept;
    v.expAddr = addr;  v.expReq = req;  v.expIRWrite = irw;  v.expBusy = busy;
    v.chkIR = chkIR;  v.expIR = ir;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v, input int idx);
    driveInputs(v.run, v.stall, 1'b0, 16'h0000, v.memAck, v.memData);
    if (v.accept) pushExp(v.memData, v.expAddr);
    #1;
    checkOutput($sformatf("vec%0d_MemReq", idx),  16'(bus.MemReq),  16'(v.expReq));
    checkOutput($sformatf("vec%0d_IRWrite", idx), 16'(bus.IRWrite), 16'(v.expIRWrite));
    checkOutput($sformatf("vec%0d_Busy", idx),    16'(bus.Busy),    16'(v.expBusy));
    if (v.expReq)  checkOutput($sformatf("vec%0d_MemAddr", idx), bus.MemAddr, v.expAddr);
    if (v.chkIR)   checkOutput($sformatf("vec%0d_IRInput", idx), bus.IRInput, v.expIR);
    tick();
  endtask

  initial begin
    //          run   stall ack   data      acc   addr     req   irw   busy  chkIR ir
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    vecs[1]  = mk(1'b1, 1'b0, 1'b1, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    vecs[2]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'hAAAA);
    vecs[3]  = mk(1'b1, 1'b0, 1'b1, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    vecs[4]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0001);
    vecs[5]  = mk(1'b1, 1'b0, 1'b1, 16'hBBBB, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    vecs[6]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'hBBBB);
    vecs[7]  = mk(1'b1, 1'b0, 1'b1, 16'h0F00, 1'b1, 16'h0003, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    vecs[8]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0F00);
    vecs[9]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0F00);
    vecs[10] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0F00);
    vecs[11] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0F00);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    vecs[13] = mk(1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 16'h0004, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234);
    vecs[15] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    vecs[16] = mk(1'b0, 1'b0, 1'b1, 16'hDEAD, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    vecs[17] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234);

    RESET_N = 1'b0;
    driveInputs(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    #2;
    checkOutput("rstMemReq",  16'(bus.MemReq),  16'h0000);
    checkOutput("rstIRWrite", 16'(bus.IRWrite), 16'h0000);
    checkOutput("rstBusy",    16'(bus.Busy),    16'h0000);
    checkOutput("rstIRInput", bus.IRInput,      16'h0000);
    checkOutput("rstPCcur",   bus.PCcur,        16'h0000);
    checkOutput("rstFromPC",  bus.fromPC,       16'h0001);
    checkOutput("rstMemAddr", bus.MemAddr,      16'h0000);
    tick();
    RESET_N = 1'b1;

    for (int i = 0; i < 18; i++) applyStimulus(vecs[i], i);

    // Redirect in IDLE, then redirect under an outstanding request whose ack arrives later.
    driveInputs(1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 16'h0000);
    #1;
    checkOutput("idleRedirBusy",   16'(bus.Busy),   16'h0000);
    checkOutput("idleRedirMemReq", 16'(bus.MemReq), 16'h0000);
    tick();
    driveInputs(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    tick();
    driveInputs(1'b1, 1'b0, 1'b1, 16'h0005, 1'b0, 16'h0000);
    #1;
    checkOutput("squashReqAddr", bus.MemAddr, 16'h0002);
    tick();
    driveInputs(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    #1;
    checkOutput("squashAddrStable", bus.MemAddr,       16'h0002);
    checkOutput("squashReqHeld",    16'(bus.MemReq),   16'h0001);
    tick();
    driveInputs(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222);
    tick();
    driveInputs(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    #1;
    checkOutput("squashNoIRWrite", 16'(bus.IRWrite), 16'h0000);
    checkOutput("squashNewAddr",   bus.MemAddr,      16'h0005);
    tick();
    driveInputs(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h5555);
    pushExp(16'h5555, 16'h0005);
    tick();
    driveInputs(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    #1;
    checkOutput("squashDeliver", 16'(bus.IRWrite), 16'h0001);
    tick();

    // Redirect coinciding with MemAck, then redirect while a delivery is stalled.
    driveInputs(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    tick();
    driveInputs(1'b1, 1'b0, 1'b1, 16'h0040, 1'b1, 16'h6666);
    #1;
    checkOutput("coincideAddr", bus.MemAddr, 16'h0006);
    tick();
    driveInputs(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    #1;
    checkOutput("coincideMemReq",  16'(bus.MemReq),  16'h0001);
    checkOutput("coincideNewAddr", bus.MemAddr,      16'h0040);
    checkOutput("coincideIRWrite", 16'(bus.IRWrite), 16'h0000);
    tick();
    driveInputs(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4040);
    pushExp(16'h4040, 16'h0040);
    tick();
    driveInputs(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    tick();
    driveInputs(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4141);
    #1;
    checkOutput("stallRedirFetchAddr", bus.MemAddr, 16'h0041);
    tick();
    driveInputs(1'b0, 1'b1, 1'b1, 16'h0100, 1'b0, 16'h0000);
    #1;
    checkOutput("stallRedirIRWrite", 16'(bus.IRWrite), 16'h0000);
    checkOutput("stallRedirIRHeld",  bus.IRInput,      16'h4141);
    tick();
    driveInputs(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    #1;
    checkOutput("stallRedirMemReq", 16'(bus.MemReq), 16'h0001);
    checkOutput("stallRedirAddr",   bus.MemAddr,     16'h0100);
    tick();
    driveInputs(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0100);
    pushExp(16'h0100, 16'h0100);
    tick();
    driveInputs(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    tick();

    // PC wrap from 0xFFFF.
    driveInputs(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0000);
    tick();
    driveInputs(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    tick();
    driveInputs(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h7777);
    pushExp(16'h7777, 16'hFFFF);
    #1;
    checkOutput("wrapFetchAddr", bus.MemAddr, 16'hFFFF);
    tick();
    driveInputs(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    #1;
    checkOutput("wrapFromPC", bus.fromPC, 16'h0000);
    tick();
    driveInputs(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111);
    pushExp(16'h1111, 16'h0000);
    #1;
    checkOutput("wrapNextAddr", bus.MemAddr, 16'h0000);
    tick();
    driveInputs(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    tick();
    #1;
    checkOutput("preResetAddr", bus.MemAddr, 16'h0001);

    // Asynchronous reset in the middle of a request, with a late ack afterwards.
    RESET_N = 1'b0;
    #1;
    checkOutput("midRstMemReq",  16'(bus.MemReq),  16'h0000);
    checkOutput("midRstBusy",    16'(bus.Busy),    16'h0000);
    checkOutput("midRstMemAddr", bus.MemAddr,      16'h0000);
    checkOutput("midRstIRInput", bus.IRInput,      16'h0000);
    checkOutput("midRstFromPC",  bus.fromPC,       16'h0001);
    driveInputs(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h9999);
    tick();
    tick();
    RESET_N = 1'b1;
    #1;
    checkOutput("postRstMemReq", 16'(bus.MemReq), 16'h0000);
    tick();
    driveInputs(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    #1;
    checkOutput("runSampledNoReq", 16'(bus.MemReq), 16'h0000);
    tick();
    #1;
    checkOutput("firstReqAfterRst", 16'(bus.MemReq), 16'h0001);
    checkOutput("firstAddrAfterRst", bus.MemAddr,    16'h0000);
    driveInputs(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h8888);
    pushExp(16'h8888, 16'h0000);
    tick();
    driveInputs(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    tick();
    tick();
    checkOutput("runDropBusy",   16'(bus.Busy),   16'h0000);
    checkOutput("runDropMemReq", 16'(bus.MemReq), 16'h0000);

    checkOutput("scoreboardDrained", 16'(expQ.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
